// File: rtl/road_fighter_pkg.sv
// rtl/road_fighter_pkg.sv - shared fixed-point constants, coordinate type and mover states
package road_fighter_pkg;
  localparam int FIXED_POINT_MULTIPLIER = 64;
  localparam int FP_SHIFT               = 6;
  localparam int SCREEN_W_DEF           = 640;
  localparam int SCREEN_H_DEF           = 480;

  typedef logic [10:0] coord_t;

  typedef enum logic [1:0] {IDLE, MOVE, EDGE, HIT} mover_state_e;
endpackage

// File: rtl/boar_object_mover_if.sv
// rtl/boar_object_mover_if.sv - scan coordinate request / bitmap offset response bundle
interface boar_object_mover_if;
  import road_fighter_pkg::*;

  coord_t pixelX;
  coord_t pixelY;
  coord_t offsetX;
  coord_t offsetY;
  logic   InsideRectangle;

  modport master (output pixelX, pixelY, input offsetX, offsetY, InsideRectangle);
  modport slave  (input pixelX, pixelY, output offsetX, offsetY, InsideRectangle);
endinterface

// File: rtl/rect_offset_calc.sv
// rtl/rect_offset_calc.sv - registered sprite box test and bitmap offset generation
module rect_offset_calc
  import road_fighter_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  coord_t i_pixel_x,
  input  coord_t i_pixel_y,
  input  coord_t i_top_x,
  input  coord_t i_top_y,
  input  coord_t i_size_w,
  input  coord_t i_size_h,
  input  logic   i_mirror,
  output coord_t o_off_x,
  output coord_t o_off_y,
  output logic   o_inside
);
  // One extra bit keeps top+size from wrapping at the right/bottom screen edge
  logic [11:0] w_px, w_py, w_tx, w_ty;
  logic        w_inside;
  coord_t      w_dx, w_dy, w_dx_sel;
  coord_t      r_off_x, r_off_y;
  logic        r_inside;

  assign w_px = {1'b0, i_pixel_x};
  assign w_py = {1'b0, i_pixel_y};
  assign w_tx = {1'b0, i_top_x};
  assign w_ty = {1'b0, i_top_y};

  assign w_inside = (w_px >= w_tx) && (w_px < w_tx + {1'b0, i_size_w}) &&
                    (w_py >= w_ty) && (w_py < w_ty + {1'b0, i_size_h});

  assign w_dx     = i_pixel_x - i_top_x;
  assign w_dy     = i_pixel_y - i_top_y;
  assign w_dx_sel = i_mirror ? (i_size_w - 11'd1 - w_dx) : w_dx;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_inside <= 1'b0;
      r_off_x  <= '0;
      r_off_y  <= '0;
    end else begin
      r_inside <= w_inside;
      r_off_x  <= w_inside ? w_dx_sel : '0;
      r_off_y  <= w_inside ? w_dy : '0;
    end
  end

  assign o_inside = r_inside;
  assign o_off_x  = r_off_x;
  assign o_off_y  = r_off_y;
endmodule

// File: rtl/boar_object_mover.sv
// rtl/boar_object_mover.sv - boar sprite position FSM with edge bounce, respawn and hit freeze
// Optional BOAR_MIRROR_EN: mirror offsetX while the boar travels left.
module boar_object_mover
  import road_fighter_pkg::*;
#(
  parameter int OBJECT_WIDTH  = 64,
  parameter int OBJECT_HEIGHT = 32,
  parameter int SCREEN_W      = SCREEN_W_DEF,
  parameter int SCREEN_H      = SCREEN_H_DEF,
  parameter int INIT_X        = 100,
  parameter int INIT_Y        = 0,
  parameter int SPEED_X       = 128,
  parameter int SPEED_Y       = 64,
  parameter int HIT_FRAMES    = 30
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   startOfFrame,
  input  logic   enable,
  input  logic   collision,
  boar_object_mover_if.slave bus,
  output coord_t topLeftX,
  output coord_t topLeftY,
  output logic   frozen
);
  localparam logic signed [17:0] P_INIT_X  = 18'(INIT_X * FIXED_POINT_MULTIPLIER);
  localparam logic signed [17:0] P_INIT_Y  = 18'(INIT_Y * FIXED_POINT_MULTIPLIER);
  localparam logic signed [17:0] P_SPEED_X = 18'(SPEED_X);
  localparam logic signed [17:0] P_SPEED_Y = 18'(SPEED_Y);
  localparam logic signed [17:0] P_LIM_X   = 18'((SCREEN_W - OBJECT_WIDTH) * FIXED_POINT_MULTIPLIER);
  localparam logic signed [17:0] P_LIM_Y   = 18'(SCREEN_H * FIXED_POINT_MULTIPLIER);
  localparam int                 CW        = $clog2(HIT_FRAMES + 1);

  mover_state_e      r_state, w_next;
  logic signed [17:0] r_pos_x, r_pos_y, r_speed_x;
  logic signed [17:0] w_sh_x, w_sh_y;
  logic [CW-1:0]     r_hit_cnt;
  logic              r_flag;
  coord_t            r_top_x, r_top_y;
  logic              w_do_move, w_do_edge, w_hit_enter, w_hit_tick, w_mirror;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (startOfFrame) begin
              if (r_flag)      w_next = HIT;
              else if (enable) w_next = MOVE;
            end
      MOVE: w_next = EDGE;
      EDGE: w_next = IDLE;
      HIT:  if (startOfFrame && r_hit_cnt == '0) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_do_move   = (r_state == MOVE);
    w_do_edge   = (r_state == EDGE);
    w_hit_enter = (r_state == IDLE) && startOfFrame && r_flag;
    w_hit_tick  = (r_state == HIT) && startOfFrame;
    frozen      = (r_state == HIT);
  end

  // A bottom respawn takes priority so the X bounce never flips speed on that frame
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pos_x   <= P_INIT_X;
      r_pos_y   <= P_INIT_Y;
      r_speed_x <= P_SPEED_X;
      r_hit_cnt <= '0;
      r_flag    <= 1'b0;
      r_top_x   <= coord_t'(INIT_X);
      r_top_y   <= coord_t'(INIT_Y);
    end else begin
      if (w_do_move) begin
        r_pos_x <= r_pos_x + r_speed_x;
        r_pos_y <= r_pos_y + P_SPEED_Y;
      end
      if (w_do_edge) begin
        if (r_pos_y >= P_LIM_Y) begin
          r_pos_x <= P_INIT_X;
          r_pos_y <= P_INIT_Y;
        end else if (r_pos_x < 0) begin
          r_pos_x   <= '0;
          r_speed_x <= -r_speed_x;
        end else if (r_pos_x >= P_LIM_X) begin
          r_pos_x   <= P_LIM_X;
          r_speed_x <= -r_speed_x;
        end
      end
      if (w_hit_enter) begin
        r_hit_cnt <= CW'(HIT_FRAMES - 1);
        r_flag    <= 1'b0;
      end else begin
        if (w_hit_tick && r_hit_cnt != '0) r_hit_cnt <= r_hit_cnt - 1'b1;
        if (collision && r_state != HIT)   r_flag    <= 1'b1;
      end
      r_top_x <= w_sh_x[10:0];
      r_top_y <= w_sh_y[10:0];
    end
  end

  assign w_sh_x   = r_pos_x >>> FP_SHIFT;
  assign w_sh_y   = r_pos_y >>> FP_SHIFT;
  assign topLeftX = r_top_x;
  assign topLeftY = r_top_y;

`ifdef BOAR_MIRROR_EN
  assign w_mirror = r_speed_x[17];
`else
  assign w_mirror = 1'b0;
`endif

  rect_offset_calc u_rect (
    .clk       (clk),
    .reset     (reset),
    .i_pixel_x (bus.pixelX),
    .i_pixel_y (bus.pixelY),
    .i_top_x   (r_top_x),
    .i_top_y   (r_top_y),
    .i_size_w  (coord_t'(OBJECT_WIDTH)),
    .i_size_h  (coord_t'(OBJECT_HEIGHT)),
    .i_mirror  (w_mirror),
    .o_off_x   (bus.offsetX),
    .o_off_y   (bus.offsetY),
    .o_inside  (bus.InsideRectangle)
  );
endmodule
